// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, EX/MEM pipeline register and an
// iterative shift-add multiplier writing HI/LO.
// Ports:
//   clock, rst (async, active-high)
//   IDEX (125-bit ID/EX bundle), IDEX_instruction (shamt in [10:6])
//   EXMEM_* registered results/controls, ex_stall, hi_out, lo_out
`timescale 1ns/1ps
module ex_stage (
   input  logic         clock,
   input  logic         rst,
   input  logic [124:0] IDEX,
   input  logic [31:0]  IDEX_instruction,
   output logic [31:0]  EXMEM_alu,
   output logic [31:0]  EXMEM_wdata,
   output logic [4:0]   EXMEM_wreg,
   output logic         EXMEM_RegWrite,
   output logic         EXMEM_MemRead,
   output logic         EXMEM_MemWrite,
   output logic         EXMEM_MemtoReg,
   output logic         EXMEM_zero,
   output logic         ex_stall,
   output logic [31:0]  hi_out,
   output logic [31:0]  lo_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  rd;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] imm;
   logic [4:0]  rt;
   logic        alu_src;
   logic        mem_to_reg;
   logic        reg_dst;
   logic [4:0]  shamt;
   logic        unused_bits;

   assign rs_val     = IDEX[31:0];
   assign rt_val     = IDEX[63:32];
   assign alu_op     = IDEX[65:64];
   assign funct      = IDEX[71:66];
   assign rd         = IDEX[76:72];
   assign reg_write  = IDEX[77];
   assign mem_read   = IDEX[78];
   assign mem_write  = IDEX[79];
   assign imm        = IDEX[111:80];
   assign rt         = IDEX[116:112];
   assign alu_src    = IDEX[117];
   assign mem_to_reg = IDEX[118];
   assign reg_dst    = IDEX[119];
   assign shamt      = IDEX_instruction[10:6];
   assign unused_bits = ^{IDEX[124:120], IDEX_instruction[31:11],
                          IDEX_instruction[5:0]};

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] mcand_q, mcand_d;
   logic [63:0] prod_q, prod_d;
   logic        sign_q, sign_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] alu_q, alu_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  wreg_q, wreg_d;
   logic        rw_q, rw_d;
   logic        mr_q, mr_d;
   logic        mw_q, mw_d;
   logic        m2r_q, m2r_d;
   logic        zero_q, zero_d;

   logic [31:0] op_b;
   logic [31:0] alu_res;
   logic        is_mul;
   logic        mul_signed;
   logic        bubble;
   logic [32:0] step_sum;
   logic [63:0] prod_step;
   logic [63:0] prod_final;

   // ALU
   always_comb begin
      op_b    = alu_src ? imm : rt_val;
      alu_res = 32'h0;
      unique case (alu_op)
         2'b00: alu_res = rs_val + op_b;
         2'b01: alu_res = rs_val - op_b;
         2'b11: alu_res = rs_val | {16'h0, imm[15:0]};
         2'b10: begin
            unique case (funct)
               6'h20, 6'h21: alu_res = rs_val + op_b;
               6'h22, 6'h23: alu_res = rs_val - op_b;
               6'h24: alu_res = rs_val & op_b;
               6'h25: alu_res = rs_val | op_b;
               6'h26: alu_res = rs_val ^ op_b;
               6'h27: alu_res = ~(rs_val | op_b);
               6'h2A: alu_res = {31'h0,
                                 $signed(rs_val) < $signed(op_b)};
               6'h2B: alu_res = {31'h0, rs_val < op_b};
               6'h00: alu_res = rt_val << shamt;
               6'h02: alu_res = rt_val >> shamt;
               6'h03: alu_res = $unsigned($signed(rt_val) >>> shamt);
               6'h10: alu_res = hi_q;
               6'h12: alu_res = lo_q;
               default: alu_res = 32'h0;
            endcase
         end
         default: alu_res = 32'h0;
      endcase
   end

   assign is_mul     = (alu_op == 2'b10) &&
                       ((funct == 6'h18) || (funct == 6'h19));
   assign mul_signed = (funct == 6'h18);

   // One multiplier bit per step: the low half of prod holds the
   // remaining multiplier bits, the high half accumulates.
   always_comb begin
      step_sum   = {1'b0, prod_q[63:32]} +
                   (prod_q[0] ? {1'b0, mcand_q} : 33'h0);
      prod_step  = {step_sum, prod_q[31:1]};
      prod_final = sign_q ? (~prod_step + 64'd1) : prod_step;
   end

   // Multiplier FSM
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      sign_d   = sign_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      ex_stall = 1'b0;
      bubble   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (is_mul) begin
               ex_stall = 1'b1;
               bubble   = 1'b1;
               state_d  = MUL;
               cnt_d    = 5'd0;
               mcand_d  = (mul_signed && rs_val[31]) ? -rs_val : rs_val;
               prod_d   = {32'h0,
                           (mul_signed && rt_val[31]) ? -rt_val : rt_val};
               sign_d   = mul_signed & (rs_val[31] ^ rt_val[31]);
            end
         end
         MUL: begin
            ex_stall = 1'b1;
            bubble   = 1'b1;
            prod_d   = prod_step;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = DONE;
               hi_d    = prod_final[63:32];
               lo_d    = prod_final[31:0];
            end
         end
         DONE: begin
            // The held mult advances out of ID/EX on this edge, so
            // going back to IDLE cannot re-trigger on it.
            bubble  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // EX/MEM next values
   always_comb begin
      alu_d   = 32'h0;
      wdata_d = 32'h0;
      wreg_d  = 5'h0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      m2r_d   = 1'b0;
      zero_d  = 1'b0;
      if (!bubble) begin
         alu_d   = alu_res;
         wdata_d = rt_val;
         wreg_d  = reg_dst ? rd : rt;
         rw_d    = reg_write;
         mr_d    = mem_read;
         mw_d    = mem_write;
         m2r_d   = mem_to_reg;
         zero_d  = (alu_res == 32'h0);
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'h0;
         mcand_q <= 32'h0;
         prod_q  <= 64'h0;
         sign_q  <= 1'b0;
         hi_q    <= 32'h0;
         lo_q    <= 32'h0;
         alu_q   <= 32'h0;
         wdata_q <= 32'h0;
         wreg_q  <= 5'h0;
         rw_q    <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         m2r_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         sign_q  <= sign_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         alu_q   <= alu_d;
         wdata_q <= wdata_d;
         wreg_q  <= wreg_d;
         rw_q    <= rw_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         m2r_q   <= m2r_d;
         zero_q  <= zero_d;
      end
   end

   assign EXMEM_alu      = alu_q;
   assign EXMEM_wdata    = wdata_q;
   assign EXMEM_wreg     = wreg_q;
   assign EXMEM_RegWrite = rw_q;
   assign EXMEM_MemRead  = mr_q;
   assign EXMEM_MemWrite = mw_q;
   assign EXMEM_MemtoReg = m2r_q;
   assign EXMEM_zero     = zero_q;
   assign hi_out         = hi_q;
   assign lo_out         = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table vectors, multiply/reset sequences and random ops
// checked against a behavioural model of the execute stage.
`timescale 1ns/1ps
module tb_ex_stage;

   logic         clock;
   logic         rst;
   logic [124:0] IDEX;
   logic [31:0]  IDEX_instruction;
   logic [31:0]  EXMEM_alu;
   logic [31:0]  EXMEM_wdata;
   logic [4:0]   EXMEM_wreg;
   logic         EXMEM_RegWrite;
   logic         EXMEM_MemRead;
   logic         EXMEM_MemWrite;
   logic         EXMEM_MemtoReg;
   logic         EXMEM_zero;
   logic         ex_stall;
   logic [31:0]  hi_out;
   logic [31:0]  lo_out;

   ex_stage dut (
      .clock            (clock),
      .rst              (rst),
      .IDEX             (IDEX),
      .IDEX_instruction (IDEX_instruction),
      .EXMEM_alu        (EXMEM_alu),
      .EXMEM_wdata      (EXMEM_wdata),
      .EXMEM_wreg       (EXMEM_wreg),
      .EXMEM_RegWrite   (EXMEM_RegWrite),
      .EXMEM_MemRead    (EXMEM_MemRead),
      .EXMEM_MemWrite   (EXMEM_MemWrite),
      .EXMEM_MemtoReg   (EXMEM_MemtoReg),
      .EXMEM_zero       (EXMEM_zero),
      .ex_stall         (ex_stall),
      .hi_out           (hi_out),
      .lo_out           (lo_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] rsv;
      logic [31:0] rtv;
      logic [31:0] imm;
      logic [1:0]  aluop;
      logic [5:0]  funct;
      logic [4:0]  rd;
      logic [4:0]  rt;
      logic [4:0]  shamt;
      logic        alusrc;
      logic        regdst;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        m2r;
   } op_t;

   typedef struct {
      string       name;
      op_t         op;
      logic [31:0] e_alu;
      logic [4:0]  e_wreg;
      logic        e_zero;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] m_hi = 32'h0;
   logic [31:0] m_lo = 32'h0;
   vec_t tbl[$];

   function automatic op_t mkop(
      input logic [31:0] rsv, input logic [31:0] rtv,
      input logic [31:0] imm, input logic [1:0] aluop,
      input logic [5:0] funct, input logic [4:0] rd,
      input logic [4:0] rt, input logic [4:0] shamt,
      input logic alusrc, input logic regdst, input logic rw,
      input logic mr, input logic mw, input logic m2r);
      op_t o;
      o.rsv = rsv; o.rtv = rtv; o.imm = imm; o.aluop = aluop;
      o.funct = funct; o.rd = rd; o.rt = rt; o.shamt = shamt;
      o.alusrc = alusrc; o.regdst = regdst; o.rw = rw;
      o.mr = mr; o.mw = mw; o.m2r = m2r;
      return o;
   endfunction

   function automatic vec_t mk(input string name, input op_t o,
      input logic [31:0] e_alu, input logic [4:0] e_wreg,
      input logic e_zero);
      vec_t v;
      v.name = name; v.op = o; v.e_alu = e_alu;
      v.e_wreg = e_wreg; v.e_zero = e_zero;
      return v;
   endfunction

   task automatic drive(input op_t o);
      IDEX = {5'd0, o.regdst, o.m2r, o.alusrc, o.rt, o.imm, o.mw,
              o.mr, o.rw, o.rd, o.funct, o.aluop, o.rtv, o.rsv};
      IDEX_instruction = {6'h0, 5'd0, o.rt, o.rd, o.shamt, o.funct};
   endtask

   function automatic logic [73:0] got_out();
      return {EXMEM_alu, EXMEM_wdata, EXMEM_wreg, EXMEM_RegWrite,
              EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg, EXMEM_zero};
   endfunction

   task automatic check(input string name, input logic [127:0] got,
                        input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   // Behavioural model of one non-multiply instruction.
   function automatic logic [73:0] model(input op_t o,
      input logic [31:0] hi, input logic [31:0] lo);
      logic [31:0] a, b, r;
      a = o.rsv;
      b = o.alusrc ? o.imm : o.rtv;
      r = 32'h0;
      case (o.aluop)
         2'd0: r = a + b;
         2'd1: r = a - b;
         2'd3: r = a | (o.imm & 32'h0000FFFF);
         default: begin
            case (o.funct)
               6'h20, 6'h21: r = a + b;
               6'h22, 6'h23: r = a - b;
               6'h24: r = a & b;
               6'h25: r = a | b;
               6'h26: r = a ^ b;
               6'h27: r = ~(a | b);
               6'h2A: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
               6'h2B: r = (a < b) ? 32'd1 : 32'd0;
               6'h00: r = o.rtv << o.shamt;
               6'h02: r = o.rtv >> o.shamt;
               6'h03: r = (o.rtv >> o.shamt) |
                          (o.rtv[31] ? ~(32'hFFFFFFFF >> o.shamt) : 32'h0);
               6'h10: r = hi;
               6'h12: r = lo;
               default: r = 32'h0;
            endcase
         end
      endcase
      return {r, o.rtv, o.regdst ? o.rd : o.rt, o.rw, o.mr, o.mw,
              o.m2r, r == 32'h0};
   endfunction

   task automatic step_op(input op_t o);
      @(negedge clock);
      drive(o);
      @(posedge clock);
      #1;
   endtask

   task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic sgn);
      op_t o, mf;
      int n;
      bit bad;
      logic [63:0] p;
      longint sa, sb;
      longint unsigned ua, ub;
      o = mkop(a, b, 32'h0, 2'b10, sgn ? 6'h18 : 6'h19, 5'd0, 5'd0,
               5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      drive(o);
      #1;
      check("mul_stall_detect", ex_stall, 1);
      n = 0;
      bad = 0;
      while (ex_stall && n < 100) begin
         @(posedge clock);
         #1;
         n++;
         if (got_out() !== 74'h0) bad = 1;
         if (ex_stall && (hi_out !== m_hi || lo_out !== m_lo)) bad = 1;
      end
      check("mul_stall_cycles", n, 33);
      check("mul_bubbles", bad, 0);
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         p = 64'(sa * sb);
      end else begin
         ua = a;
         ub = b;
         p = ua * ub;
      end
      m_hi = p[63:32];
      m_lo = p[31:0];
      check("mul_hilo", {hi_out, lo_out}, p);
      mf = mkop(32'h0, 32'h0, 32'h0, 2'b10, 6'h10, 5'd2, 5'd0, 5'd0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      drive(mf);
      @(posedge clock);
      #1;
      check("mul_done_bubble", got_out(), 74'h0);
      check("mul_done_stall", ex_stall, 0);
      @(posedge clock);
      #1;
      check("mfhi", got_out(), model(mf, m_hi, m_lo));
      mf.funct = 6'h12;
      step_op(mf);
      check("mflo", got_out(), model(mf, m_hi, m_lo));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      op_t nop, o;
      vec_t v;
      logic [5:0] f;

      nop = mkop(0, 0, 0, 2'b00, 6'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl.push_back(mk("add", mkop(5, 7, 0, 2'b10, 6'h20, 3, 0, 0,
                   0, 1, 1, 0, 0, 0), 32'd12, 5'd3, 1'b0));
      tbl.push_back(mk("lw", mkop(32'h100, 0, 32'hFFFFFFFC, 2'b00, 6'h0,
                   0, 8, 0, 1, 0, 0, 1, 0, 1), 32'hFC, 5'd8, 1'b0));
      tbl.push_back(mk("sw", mkop(32'h1000, 32'hDEADBEEF, 32'h8, 2'b00,
                   6'h0, 0, 4, 0, 1, 0, 0, 0, 1, 0), 32'h1008, 5'd4, 1'b0));
      tbl.push_back(mk("beq", mkop(9, 9, 0, 2'b01, 6'h0, 0, 9, 0,
                   0, 0, 0, 0, 0, 0), 32'h0, 5'd9, 1'b1));
      tbl.push_back(mk("slt", mkop(32'hFFFFFFFF, 1, 0, 2'b10, 6'h2A, 4, 0,
                   0, 0, 1, 1, 0, 0, 0), 32'd1, 5'd4, 1'b0));
      tbl.push_back(mk("sltu", mkop(32'hFFFFFFFF, 1, 0, 2'b10, 6'h2B, 4, 0,
                   0, 0, 1, 1, 0, 0, 0), 32'd0, 5'd4, 1'b1));
      tbl.push_back(mk("sra", mkop(0, 32'h80000000, 0, 2'b10, 6'h03, 5, 0,
                   4, 0, 1, 1, 0, 0, 0), 32'hF8000000, 5'd5, 1'b0));
      tbl.push_back(mk("ori", mkop(32'h12340000, 0, 32'hFFFF8001, 2'b11,
                   6'h0, 0, 6, 0, 1, 0, 1, 0, 0, 0), 32'h12348001, 5'd6,
                   1'b0));
      tbl.push_back(mk("nor", mkop(0, 0, 0, 2'b10, 6'h27, 7, 0, 0,
                   0, 1, 1, 0, 0, 0), 32'hFFFFFFFF, 5'd7, 1'b0));
      tbl.push_back(mk("sub", mkop(3, 5, 0, 2'b10, 6'h22, 8, 0, 0,
                   0, 1, 1, 0, 0, 0), 32'hFFFFFFFE, 5'd8, 1'b0));
      tbl.push_back(mk("subu", mkop(5, 5, 0, 2'b10, 6'h23, 8, 0, 0,
                   0, 1, 1, 0, 0, 0), 32'h0, 5'd8, 1'b1));
      tbl.push_back(mk("undef", mkop(32'hAAAA, 32'h5555, 0, 2'b10, 6'h3F,
                   9, 0, 0, 0, 1, 1, 0, 0, 0), 32'h0, 5'd9, 1'b1));
      tbl.push_back(mk("sll", mkop(0, 1, 0, 2'b10, 6'h00, 10, 0, 31,
                   0, 1, 1, 0, 0, 0), 32'h80000000, 5'd10, 1'b0));
      tbl.push_back(mk("srl", mkop(0, 32'h80000000, 0, 2'b10, 6'h02, 11, 0,
                   31, 0, 1, 1, 0, 0, 0), 32'h1, 5'd11, 1'b0));
      tbl.push_back(mk("addu_wrap", mkop(32'hFFFFFFFF, 1, 0, 2'b10, 6'h21,
                   12, 0, 0, 0, 1, 1, 0, 0, 0), 32'h0, 5'd12, 1'b1));
      tbl.push_back(mk("xor", mkop(32'hF0F0, 32'hFF00, 0, 2'b10, 6'h26, 13,
                   0, 0, 0, 1, 1, 0, 0, 0), 32'h0FF0, 5'd13, 1'b0));
      tbl.push_back(mk("and", mkop(32'hF0F0, 32'hFF00, 0, 2'b10, 6'h24, 14,
                   0, 0, 0, 1, 1, 0, 0, 0), 32'hF000, 5'd14, 1'b0));
      tbl.push_back(mk("or", mkop(32'hF0F0, 32'hFF00, 0, 2'b10, 6'h25, 15,
                   0, 0, 0, 1, 1, 0, 0, 0), 32'hFFF0, 5'd15, 1'b0));
      tbl.push_back(mk("mfhi0", mkop(0, 0, 0, 2'b10, 6'h10, 16, 0, 0,
                   0, 1, 1, 0, 0, 0), 32'h0, 5'd16, 1'b1));
      tbl.push_back(mk("mflo0", mkop(0, 0, 0, 2'b10, 6'h12, 17, 0, 0,
                   0, 1, 1, 0, 0, 0), 32'h0, 5'd17, 1'b1));

      rst = 1'b1;
      drive(nop);
      #3;
      check("reset_exmem", got_out(), 74'h0);
      check("reset_hilo", {hi_out, lo_out}, 64'h0);
      check("reset_stall", ex_stall, 0);
      @(negedge clock);
      @(negedge clock);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         step_op(v.op);
         check(v.name, got_out(),
               {v.e_alu, v.op.rtv, v.e_wreg, v.op.rw, v.op.mr, v.op.mw,
                v.op.m2r, v.e_zero});
      end

      run_mult(32'hFFFFFFFD, 32'd7, 1'b1);
      check("mult_neg3x7", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
      run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      check("multu_max", {hi_out, lo_out}, 64'hFFFFFFFE_00000001);
      run_mult(32'h80000000, 32'h80000000, 1'b1);
      run_mult(32'h80000000, 32'hFFFFFFFF, 1'b1);

      // Reset while the multiplier is mid-run.
      o = mkop(32'h12345678, 32'h9, 0, 2'b10, 6'h19, 0, 0, 0,
               0, 1, 0, 0, 0, 0);
      @(negedge clock);
      drive(o);
      repeat (11) @(posedge clock);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_exmem", got_out(), 74'h0);
      check("midrst_hilo", {hi_out, lo_out}, 64'h0);
      check("midrst_stall_held", ex_stall, 1);
      drive(nop);
      #1;
      check("midrst_stall_drop", ex_stall, 0);
      m_hi = 32'h0;
      m_lo = 32'h0;
      @(negedge clock);
      rst = 1'b0;
      step_op(tbl[0].op);
      check("post_rst_add", got_out(), model(tbl[0].op, m_hi, m_lo));
      o = mkop(0, 0, 0, 2'b10, 6'h12, 3, 0, 0, 0, 1, 1, 0, 0, 0);
      step_op(o);
      check("post_rst_mflo", got_out(), model(o, m_hi, m_lo));

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            run_mult($urandom, $urandom, 1'($urandom_range(0, 1)));
         end else begin
            f = 6'($urandom_range(0, 63));
            if (f == 6'h18 || f == 6'h19) f = 6'h3F;
            o = mkop($urandom, $urandom, $urandom,
                     2'($urandom_range(0, 3)), f,
                     5'($urandom), 5'($urandom), 5'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 7) == 0) o.rtv = o.rsv;
            step_op(o);
            check("rand_op", got_out(), model(o, m_hi, m_lo));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
